regfile_write_bank: RTL and testbench

Register storage and write port of the 32-entry register file; sits directly upstream of the read ports and drives the per-register data they select from. Commits one write per clock, hardwires register 0 to zero, and keeps a per-register busy scoreboard (reserve on issue, clear on writeback) for the pipeline hazard logic. Outputs are registered; read ports stay combinational on top of them.

---
 rtl/regfile_write_bank.sv | 96 +++++++++
 tb/tb_regfile_write_bank.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_bank.sv
// Register storage and write port of the register file, with a per-register
// busy scoreboard. Register 0 always reads as zero and can never be busy.
module regfile_write_bank #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                           clock,
    input  logic                           ctrl_reset,
    input  logic                           ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0]          ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0]          data_writeReg,
    input  logic                           ctrl_reserveEnable,
    input  logic [ADDR_WIDTH-1:0]          ctrl_reserveReg,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_data_bus,
    output logic [NUM_REGS-1:0]            reg_busy,
    output logic                           write_ack,
    output logic                           stale_write
);

    // Storage exists only for registers 1..NUM_REGS-1; register 0 is a constant.
    logic [DATA_WIDTH-1:0] data_q [1:NUM_REGS-1];
    logic [NUM_REGS-1:1]   busy_q;

    logic [NUM_REGS-1:0]   wr_sel;
    logic [NUM_REGS-1:0]   rsv_sel;
    logic [NUM_REGS-1:0]   busy_full;
    logic                  write_hit;

    assign busy_full = {busy_q, 1'b0};
    assign write_hit = ctrl_writeEnable && (ctrl_writeReg != ADDR_WIDTH'(0));

    // One-hot write and reserve decode; register 0 is masked off so it is never touched.
    always_comb begin
        wr_sel  = '0;
        rsv_sel = '0;
        if (ctrl_writeEnable) begin
            wr_sel[ctrl_writeReg] = 1'b1;
        end
        if (ctrl_reserveEnable) begin
            rsv_sel[ctrl_reserveReg] = 1'b1;
        end
        wr_sel[0]  = 1'b0;
        rsv_sel[0] = 1'b0;
    end

    // Register storage: at most one register captures the write data per edge.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    data_q[i] <= data_writeReg;
                end
            end
        end
    end

    // Busy scoreboard: a new reservation wins over a completing write on the same edge.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            busy_q <= '0;
        end else begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (rsv_sel[i]) begin
                    busy_q[i] <= 1'b1;
                end else if (wr_sel[i]) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    // Single-cycle status pulses; stale uses the busy value from before this edge.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            write_ack   <= 1'b0;
            stale_write <= 1'b0;
        end else begin
            write_ack   <= write_hit;
            stale_write <= write_hit && !busy_full[ctrl_writeReg];
        end
    end

    assign reg_busy = busy_full;

    // Flatten register contents onto the read-port bus.
    assign reg_data_bus[DATA_WIDTH-1:0] = '0;
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_field
        assign reg_data_bus[g*DATA_WIDTH +: DATA_WIDTH] = data_q[g];
    end

endmodule

// File: tb/tb_regfile_write_bank.sv
// Scoreboard bench for regfile_write_bank: directed steps push expected
// post-edge state, a negedge monitor pops and compares.
module tb_regfile_write_bank;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 32;
    localparam int unsigned AW = 5;

    logic              clock = 1'b0;
    logic              ctrl_reset;
    logic              ctrl_writeEnable;
    logic [AW-1:0]     ctrl_writeReg;
    logic [DW-1:0]     data_writeReg;
    logic              ctrl_reserveEnable;
    logic [AW-1:0]     ctrl_reserveReg;
    logic [NR*DW-1:0]  reg_data_bus;
    logic [NR-1:0]     reg_busy;
    logic              write_ack;
    logic              stale_write;

    regfile_write_bank #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
        .clock              (clock),
        .ctrl_reset         (ctrl_reset),
        .ctrl_writeEnable   (ctrl_writeEnable),
        .ctrl_writeReg      (ctrl_writeReg),
        .data_writeReg      (data_writeReg),
        .ctrl_reserveEnable (ctrl_reserveEnable),
        .ctrl_reserveReg    (ctrl_reserveReg),
        .reg_data_bus       (reg_data_bus),
        .reg_busy           (reg_busy),
        .write_ack          (write_ack),
        .stale_write        (stale_write)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned      due;
        logic             ack;
        logic             stale;
        logic [NR-1:0]    busy;
        logic [NR*DW-1:0] bus;
        string            tag;
    } exp_t;

    exp_t          sbq[$];
    int            checks = 0;
    int            errors = 0;
    int unsigned   cyc = 0;
    logic [DW-1:0] shadow [NR];

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bus(input string name, input logic [NR*DW-1:0] exp);
        int bad;
        bad = -1;
        for (int f = NR - 1; f >= 0; f--) begin
            if (reg_data_bus[f*DW +: DW] !== exp[f*DW +: DW]) bad = f;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: reg%0d got %h expected %h", name, bad,
                     reg_data_bus[bad*DW +: DW], exp[bad*DW +: DW]);
        end
    endtask

    function automatic logic [NR*DW-1:0] flat_shadow();
        logic [NR*DW-1:0] b;
        for (int i = 0; i < NR; i++) b[i*DW +: DW] = shadow[i];
        return b;
    endfunction

    // Monitor: compare every scoreboard entry once its commit edge has passed.
    always @(negedge clock) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            if (e.due != cyc) begin
                check({e.tag, "_late"}, 64'(cyc), 64'(e.due));
            end else begin
                check({e.tag, "_ack"},   64'(write_ack),   64'(e.ack));
                check({e.tag, "_stale"}, 64'(stale_write), 64'(e.stale));
                check({e.tag, "_busy"},  64'(reg_busy),    64'(e.busy));
                check_bus({e.tag, "_bus"}, e.bus);
            end
        end
    end

    // Drive one cycle of stimulus and queue the state expected after the next edge.
    task automatic step(input logic we, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                        input logic re, input logic [AW-1:0] rr,
                        input logic e_ack, input logic e_stale, input logic [NR-1:0] e_busy,
                        input string tag);
        exp_t e;
        @(negedge clock);
        ctrl_writeEnable   = we;
        ctrl_writeReg      = wr;
        data_writeReg      = wd;
        ctrl_reserveEnable = re;
        ctrl_reserveReg    = rr;
        if (e_ack) shadow[wr] = wd;
        e.due   = cyc + 1;
        e.ack   = e_ack;
        e.stale = e_stale;
        e.busy  = e_busy;
        e.bus   = flat_shadow();
        e.tag   = tag;
        sbq.push_back(e);
    endtask

    task automatic idle(input logic [NR-1:0] e_busy, input string tag);
        step(1'b0, AW'(0), DW'(0), 1'b0, AW'(0), 1'b0, 1'b0, e_busy, tag);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (sbq.size() > 0) begin
            check("drain_timeout", 64'(sbq.size()), 64'(0));
            sbq.delete();
        end
        @(negedge clock);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},   64'(write_ack),   64'(0));
        check({tag, "_stale"}, 64'(stale_write), 64'(0));
        check({tag, "_busy"},  64'(reg_busy),    64'(0));
        check({tag, "_bus"},   64'(reg_data_bus == '0), 64'(1));
    endtask

    initial begin
        ctrl_reset         = 1'b1;
        ctrl_writeEnable   = 1'b0;
        ctrl_writeReg      = '0;
        data_writeReg      = '0;
        ctrl_reserveEnable = 1'b0;
        ctrl_reserveReg    = '0;
        for (int i = 0; i < NR; i++) shadow[i] = '0;

        #12;
        check_all_zero("init_reset");
        @(negedge clock);
        ctrl_reset = 1'b0;

        // reserve then write r5
        step(1'b0, AW'(0),  DW'(0),            1'b1, AW'(5),  1'b0, 1'b0, 32'h0000_0020, "rsv_r5");
        step(1'b1, AW'(5),  32'hDEAD_BEEF,     1'b0, AW'(0),  1'b1, 1'b0, 32'h0000_0000, "wr_r5");
        idle(32'h0000_0000, "idle1");
        // register 0 is immune to writes and reserves
        step(1'b1, AW'(0),  32'hFFFF_FFFF,     1'b1, AW'(0),  1'b0, 1'b0, 32'h0000_0000, "wr_r0");
        // write and re-reserve r7 on the same edge
        step(1'b0, AW'(0),  DW'(0),            1'b1, AW'(7),  1'b0, 1'b0, 32'h0000_0080, "rsv_r7");
        step(1'b1, AW'(7),  32'h1234_5678,     1'b1, AW'(7),  1'b1, 1'b0, 32'h0000_0080, "wr_rsv_r7");
        // unreserved write flags stale
        step(1'b1, AW'(9),  32'h0000_0055,     1'b0, AW'(0),  1'b1, 1'b1, 32'h0000_0080, "wr_r9");
        idle(32'h0000_0080, "idle2");
        // back-to-back writes
        step(1'b1, AW'(31), 32'h0000_0001,     1'b0, AW'(0),  1'b1, 1'b1, 32'h0000_0080, "wr_r31a");
        step(1'b1, AW'(31), 32'h0000_0002,     1'b0, AW'(0),  1'b1, 1'b1, 32'h0000_0080, "wr_r31b");
        step(1'b1, AW'(1),  32'h0000_0003,     1'b0, AW'(0),  1'b1, 1'b1, 32'h0000_0080, "wr_r1");
        // double reserve stays busy
        step(1'b0, AW'(0),  DW'(0),            1'b1, AW'(3),  1'b0, 1'b0, 32'h0000_0088, "rsv_r3a");
        step(1'b0, AW'(0),  DW'(0),            1'b1, AW'(3),  1'b0, 1'b0, 32'h0000_0088, "rsv_r3b");
        // X address with write disabled changes nothing
        step(1'b0, 'x,      'x,                1'b1, AW'(12), 1'b0, 1'b0, 32'h0000_1088, "wr_x_dis");
        step(1'b1, AW'(3),  32'h0000_A5A5,     1'b1, AW'(13), 1'b1, 1'b0, 32'h0000_3080, "wr_r3");
        step(1'b1, AW'(7),  32'h0000_00AA,     1'b0, AW'(0),  1'b1, 1'b0, 32'h0000_3000, "wr_r7b");
        idle(32'h0000_3000, "idle3");
        drain();

        // asynchronous reset mid-cycle with live data and busy bits
        @(posedge clock);
        #2 ctrl_reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clock);
        ctrl_writeEnable   = 1'b1;
        ctrl_writeReg      = AW'(4);
        data_writeReg      = 32'h0000_0099;
        ctrl_reserveEnable = 1'b1;
        ctrl_reserveReg    = AW'(4);
        @(posedge clock);
        #1 check_all_zero("reset_held");
        @(negedge clock);
        ctrl_writeEnable   = 1'b0;
        ctrl_reserveEnable = 1'b0;
        ctrl_reset         = 1'b0;
        for (int i = 0; i < NR; i++) shadow[i] = '0;

        // busy was cleared by reset, so this write is stale
        step(1'b1, AW'(12), 32'h0000_0077,     1'b0, AW'(0),  1'b1, 1'b1, 32'h0000_0000, "wr_r12_post");
        idle(32'h0000_0000, "idle4");
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: got %0d expected 0", sbq.size());
        $fatal(1);
    end

endmodule
